// File: rtl/uar_dp_pkg.sv
// Shared definitions for the UART receive datapath: the receive state
// encodings used by the paired state machine, counter limits, and a helper
// that classifies the three state-machine strobes.
package uar_dp_pkg;

    // One-hot encodings of the receive state machine that drives this datapath.
    typedef enum logic [3:0] {
        IDLE         = 4'b0001,
        START_BIT_ST = 4'b0010,
        DATA_BITS_ST = 4'b0100,
        STOP_BIT_ST  = 4'b1000
    } uar_state_e;

    // shift_count value once the eighth data bit has been taken.
    localparam logic [3:0] SHIFT_LAST       = 4'd9;
    // count_sample value at which the state machine leaves the stop state.
    localparam logic [3:0] STOP_EXIT        = 4'd9;
    // Default mid-bit sampling position of the 16x counter.
    localparam logic [3:0] SAMPLE_POINT_DEF = 4'd7;

    // What the datapath should do this cycle, derived from the strobes.
    typedef enum logic [2:0] {
        MODE_IDLE,
        MODE_START,
        MODE_DATA,
        MODE_STOP,
        MODE_ILLEGAL
    } rx_mode_e;

    // Exactly one strobe selects a phase; none is idle; several is illegal.
    function automatic rx_mode_e decode_mode(input logic start_bit,
                                             input logic data_bits,
                                             input logic stop_bit);
        case ({start_bit, data_bits, stop_bit})
            3'b000:  return MODE_IDLE;
            3'b100:  return MODE_START;
            3'b010:  return MODE_DATA;
            3'b001:  return MODE_STOP;
            default: return MODE_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/uar_sync.sv
// Multi-flop synchroniser for the asynchronous serial line, plus a one-cycle
// delayed copy and a falling-edge flag. Every flop resets to the idle-high
// line level so no spurious edge appears when reset is released.
module uar_sync #(
    parameter int STAGES = 2              // minimum 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic [STAGES-1:0] stages;
    logic              prev;

    // Shift the raw line through the synchroniser and keep the previous value.
    // NOTE: non-blocking assignments so every stage samples the value its
    // predecessor held before this edge; blocking would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '1;
            prev   <= 1'b1;
        end else begin
            stages <= {stages[STAGES-2:0], din};
            prev   <= stages[STAGES-1];
        end
    end

    assign sync = stages[STAGES-1];
    assign fall = prev & ~sync;

endmodule

// File: rtl/uar_dp.sv
// UART receive datapath. Synchronises the line, flags the start edge while
// idle, runs the 16x sample counter and the bit counter under control of the
// external state machine, assembles the byte LSB-first and reports either a
// good byte (rx_valid) or a framing error (frame_err) for one cycle.
module uar_dp
    import uar_dp_pkg::*;
#(
    parameter logic [3:0] SAMPLE_POINT = SAMPLE_POINT_DEF,  // legal 0..8
    parameter int         SYNC_STAGES  = 2                  // minimum 2
) (
    input  logic       clk_16x,
    input  logic       rst_p,
    input  logic       rx_in,
    input  logic       start_bit_sig,
    input  logic       data_bits_sig,
    input  logic       stop_bit_sig,
    output logic       din_rdy,
    output logic [3:0] shift_count,
    output logic [3:0] count_sample,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    logic       rx_sync;
    logic       rx_fall;
    logic [7:0] shift_reg;
    logic       start_err;
    rx_mode_e   mode;
    logic       at_sample;
    logic       take_data;

    uar_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk_16x),
        .rst  (rst_p),
        .din  (rx_in),
        .sync (rx_sync),
        .fall (rx_fall)
    );

    assign mode      = decode_mode(start_bit_sig, data_bits_sig, stop_bit_sig);
    assign at_sample = (count_sample == SAMPLE_POINT);
    // A data bit is taken once per bit time until all eight are in.
    assign take_data = (mode == MODE_DATA) && at_sample && (shift_count < SHIFT_LAST);

    // Start edge is only meaningful while the state machine is idle.
    assign din_rdy = (mode == MODE_IDLE) && rx_fall;

    // Sample counter, bit counter and start-bit error flag.
    always_ff @(posedge clk_16x or posedge rst_p) begin
        if (rst_p) begin
            count_sample <= 4'd0;
            shift_count  <= 4'd0;
            start_err    <= 1'b0;
        end else begin
            case (mode)
                MODE_START: begin
                    count_sample <= count_sample + 4'd1;
                    // Advance unconditionally so the state machine never
                    // stalls on a false start; the error surfaces at the stop.
                    if (at_sample) begin
                        shift_count <= 4'd1;
                        start_err   <= rx_sync;
                    end
                end
                MODE_DATA: begin
                    // Restart the count after the last data bit so the stop
                    // phase begins at zero.
                    if (shift_count == SHIFT_LAST)
                        count_sample <= 4'd0;
                    else
                        count_sample <= count_sample + 4'd1;
                    if (take_data)
                        shift_count <= shift_count + 4'd1;
                end
                MODE_STOP: begin
                    count_sample <= count_sample + 4'd1;
                end
                default: begin
                    // Idle or conflicting strobes: park both counters.
                    count_sample <= 4'd0;
                    shift_count  <= 4'd0;
                    start_err    <= 1'b0;
                end
            endcase
        end
    end

    // Assemble the byte LSB-first: each new bit enters at the top.
    // NOTE: the shift register is reset even though its contents are only
    // consumed after eight fresh bits; it is small and a defined value keeps
    // simulation free of X on an aborted frame.
    always_ff @(posedge clk_16x or posedge rst_p) begin
        if (rst_p)
            shift_reg <= 8'h00;
        else if (take_data)
            shift_reg <= {rx_sync, shift_reg[7:1]};
    end

    // Judge the stop bit and publish either the byte or a framing error.
    always_ff @(posedge clk_16x or posedge rst_p) begin
        if (rst_p) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if ((mode == MODE_STOP) && at_sample) begin
                if (rx_sync && !start_err) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uar_dp.sv
// Self-checking bench for uar_dp. Contains a small receive state machine to
// drive the strobes, serialises frames onto rx_in at 16 clocks per bit and
// compares the reported bytes/errors against a frame-level expectation.
module tb_uar_dp;
    import uar_dp_pkg::*;

    logic       clk_16x = 1'b0;
    logic       rst_p;
    logic       rx_in;
    logic       start_bit_sig;
    logic       data_bits_sig;
    logic       stop_bit_sig;
    logic       din_rdy;
    logic [3:0] shift_count;
    logic [3:0] count_sample;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_16x = ~clk_16x;

    uar_dp #(
        .SAMPLE_POINT (SAMPLE_POINT_DEF),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_16x       (clk_16x),
        .rst_p         (rst_p),
        .rx_in         (rx_in),
        .start_bit_sig (start_bit_sig),
        .data_bits_sig (data_bits_sig),
        .stop_bit_sig  (stop_bit_sig),
        .din_rdy       (din_rdy),
        .shift_count   (shift_count),
        .count_sample  (count_sample),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .frame_err     (frame_err)
    );

    // Receive state machine paired with the datapath.
    uar_state_e st;
    logic       force_ill = 1'b0;

    always @(posedge clk_16x or posedge rst_p) begin
        if (rst_p) begin
            st <= IDLE;
        end else begin
            case (st)
                IDLE:         if (din_rdy) st <= START_BIT_ST;
                START_BIT_ST: if (count_sample == 4'd15) st <= DATA_BITS_ST;
                DATA_BITS_ST: if (shift_count == SHIFT_LAST) st <= STOP_BIT_ST;
                STOP_BIT_ST:  if (count_sample == STOP_EXIT) st <= IDLE;
                default:      st <= IDLE;
            endcase
        end
    end

    assign start_bit_sig = (st == START_BIT_ST) | force_ill;
    assign data_bits_sig = (st == DATA_BITS_ST) & ~force_ill;
    assign stop_bit_sig  = (st == STOP_BIT_ST)  | force_ill;

    // Output monitor, sampled on the falling edge.
    int         cyc = 0;
    int         valid_cyc[$];
    logic [7:0] valid_data[$];
    int         ferr_cyc[$];
    int         both_cyc[$];
    logic [3:0] sc_trace[$];

    always @(posedge clk_16x) cyc <= cyc + 1;

    always @(negedge clk_16x) begin
        if (rx_valid) begin
            valid_cyc.push_back(cyc);
            valid_data.push_back(rx_data);
        end
        if (frame_err) ferr_cyc.push_back(cyc);
        if (rx_valid && frame_err) both_cyc.push_back(cyc);
        if (sc_trace.size() == 0 || sc_trace[$] != shift_count) sc_trace.push_back(shift_count);
    end

    // Reference: last byte that should be sitting in rx_data.
    logic [7:0] last_good = 8'h00;

    // A frame is good when its start bit is still low past mid-bit
    // (8 of 16 clocks) and its stop bit is high.
    localparam int MID_BIT = 8;
    function automatic bit frame_ok(input int start_low_clocks, input logic stop);
        return (start_low_clocks > MID_BIT) && stop;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_16x);
            #1;
        end
    endtask

    task automatic clear_mon();
        valid_cyc.delete();
        valid_data.delete();
        ferr_cyc.delete();
        sc_trace.delete();
    endtask

    task automatic drive_bits(input logic [9:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_in = bits[i];
            tick(16);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bits({stop, d, 1'b0}, 10);
    endtask

    function automatic logic [7:0] first_data();
        return (valid_data.size() > 0) ? valid_data[0] : 8'hxx;
    endfunction

    task automatic test_reset();
        rst_p = 1'b1;
        rx_in = 1'b1;
        tick(3);
        tests_run++;
        if ({count_sample, shift_count} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_counters: got %h expected 00", {count_sample, shift_count});
        end
        tests_run++;
        if (rx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_rx_data: got %h expected 00", rx_data);
        end
        tests_run++;
        if ({rx_valid, frame_err, din_rdy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000", {rx_valid, frame_err, din_rdy});
        end
        rst_p = 1'b0;
        tick(5);
        last_good = 8'h00;
    endtask

    task automatic test_frame_a5();
        logic ok;
        clear_mon();
        send_frame(8'hA5, 1'b1);
        rx_in = 1'b1;
        tick(40);
        tests_run++;
        if (valid_cyc.size() !== 1 || first_data() !== 8'hA5) begin
            tests_failed++;
            $display("FAIL a5_valid: got %0d pulses data %h expected 1 pulse data a5",
                     valid_cyc.size(), first_data());
        end
        last_good = 8'hA5;
        tests_run++;
        if (ferr_cyc.size() !== 0) begin
            tests_failed++;
            $display("FAIL a5_frame_err: got %0d expected 0", ferr_cyc.size());
        end
        ok = (sc_trace.size() == 11);
        for (int i = 0; i < 11 && ok; i++)
            if (sc_trace[i] != ((i == 10) ? 4'd0 : 4'(i))) ok = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL a5_shift_count_seq: got %p expected 0..9,0", sc_trace);
        end
    endtask

    task automatic test_start_glitch();
        bit exp_ok;
        clear_mon();
        exp_ok = frame_ok(3, 1'b1);
        rx_in = 1'b0;
        tick(3);
        rx_in = 1'b1;
        tick(200);
        tests_run++;
        if (valid_cyc.size() !== (exp_ok ? 1 : 0) || ferr_cyc.size() !== (exp_ok ? 0 : 1)) begin
            tests_failed++;
            $display("FAIL glitch_outcome: got valid=%0d ferr=%0d expected valid=0 ferr=1",
                     valid_cyc.size(), ferr_cyc.size());
        end
        tests_run++;
        if (rx_data !== last_good) begin
            tests_failed++;
            $display("FAIL glitch_rx_data: got %h expected %h", rx_data, last_good);
        end
    endtask

    task automatic test_bad_stop();
        clear_mon();
        send_frame(8'h3C, 1'b0);
        rx_in = 1'b1;
        tick(30);
        tests_run++;
        if (valid_cyc.size() !== 0 || ferr_cyc.size() !== 1) begin
            tests_failed++;
            $display("FAIL bad_stop_outcome: got valid=%0d ferr=%0d expected valid=0 ferr=1",
                     valid_cyc.size(), ferr_cyc.size());
        end
        tests_run++;
        if (rx_data !== last_good) begin
            tests_failed++;
            $display("FAIL bad_stop_rx_data: got %h expected %h", rx_data, last_good);
        end
        tests_run++;
        if ({count_sample, shift_count} !== 8'h00) begin
            tests_failed++;
            $display("FAIL bad_stop_idle_counters: got %h expected 00", {count_sample, shift_count});
        end
        clear_mon();
        send_frame(8'h81, 1'b1);
        rx_in = 1'b1;
        tick(30);
        tests_run++;
        if (valid_cyc.size() !== 1 || first_data() !== 8'h81 || ferr_cyc.size() !== 0) begin
            tests_failed++;
            $display("FAIL after_bad_stop_81: got %0d pulses data %h ferr %0d expected 1 pulse data 81 ferr 0",
                     valid_cyc.size(), first_data(), ferr_cyc.size());
        end
        last_good = 8'h81;
    endtask

    task automatic test_back_to_back();
        int gap;
        clear_mon();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        rx_in = 1'b1;
        tick(40);
        tests_run++;
        if (valid_cyc.size() !== 2 || ferr_cyc.size() !== 0) begin
            tests_failed++;
            $display("FAIL b2b_count: got valid=%0d ferr=%0d expected valid=2 ferr=0",
                     valid_cyc.size(), ferr_cyc.size());
        end else begin
            tests_run++;
            if (valid_data[0] !== 8'h00 || valid_data[1] !== 8'hFF) begin
                tests_failed++;
                $display("FAIL b2b_data: got %h %h expected 00 ff", valid_data[0], valid_data[1]);
            end
            gap = valid_cyc[1] - valid_cyc[0];
            tests_run++;
            if (gap < 159 || gap > 161) begin
                tests_failed++;
                $display("FAIL b2b_spacing: got %0d expected 160+-1", gap);
            end
        end
        last_good = 8'hFF;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        drive_bits({1'b1, 8'hC3, 1'b0}, 5);
        rx_in = 1'b0;             // bit 4 of 0xC3
        tick(8);
        rst_p = 1'b1;
        tick(2);
        tests_run++;
        if ({count_sample, shift_count} !== 8'h00) begin
            tests_failed++;
            $display("FAIL midreset_counters: got %h expected 00", {count_sample, shift_count});
        end
        rx_in = 1'b1;
        rst_p = 1'b0;
        last_good = 8'h00;
        tick(200);
        tests_run++;
        if (valid_cyc.size() !== 0 || ferr_cyc.size() !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_pulse: got valid=%0d ferr=%0d expected 0 0",
                     valid_cyc.size(), ferr_cyc.size());
        end
        clear_mon();
        send_frame(8'h5A, 1'b1);
        rx_in = 1'b1;
        tick(30);
        tests_run++;
        if (valid_cyc.size() !== 1 || first_data() !== 8'h5A || ferr_cyc.size() !== 0) begin
            tests_failed++;
            $display("FAIL midreset_next_5a: got %0d pulses data %h expected 1 pulse data 5a",
                     valid_cyc.size(), first_data());
        end
        last_good = 8'h5A;
    endtask

    task automatic test_illegal();
        clear_mon();
        force_ill = 1'b1;
        tick(2);
        rx_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            tests_run++;
            if ({count_sample, shift_count, din_rdy} !== 9'd0) begin
                tests_failed++;
                $display("FAIL illegal_cycle%0d: got cs=%0d sc=%0d din_rdy=%b expected 0 0 0",
                         i, count_sample, shift_count, din_rdy);
            end
        end
        rx_in = 1'b1;
        tick(5);
        force_ill = 1'b0;
        tick(20);
        tests_run++;
        if (valid_cyc.size() !== 0 || ferr_cyc.size() !== 0 || rx_data !== last_good) begin
            tests_failed++;
            $display("FAIL illegal_quiet: got valid=%0d ferr=%0d data=%h expected 0 0 %h",
                     valid_cyc.size(), ferr_cyc.size(), rx_data, last_good);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       stop;
        bit         exp_ok;
        for (int n = 0; n < 12; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            exp_ok = frame_ok(16, stop);
            clear_mon();
            send_frame(d, stop);
            rx_in = 1'b1;
            tick(20);
            if (exp_ok) last_good = d;
            tests_run++;
            if (valid_cyc.size() !== (exp_ok ? 1 : 0) || ferr_cyc.size() !== (exp_ok ? 0 : 1)
                || rx_data !== last_good) begin
                tests_failed++;
                $display("FAIL random%0d (d=%h stop=%b): got valid=%0d ferr=%0d data=%h expected valid=%0d data=%h",
                         n, d, stop, valid_cyc.size(), ferr_cyc.size(), rx_data, exp_ok, last_good);
            end
        end
    endtask

    initial begin
        rst_p = 1'b1;
        rx_in = 1'b1;
        test_reset();
        test_frame_a5();
        test_start_glitch();
        test_bad_stop();
        test_back_to_back();
        test_reset_mid();
        test_illegal();
        test_random();
        tests_run++;
        if (both_cyc.size() !== 0) begin
            tests_failed++;
            $display("FAIL valid_and_err_together: got %0d cycles expected 0", both_cyc.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
